dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
Direct-mapped, write-back, write-allocate data cache that sits between the RV32IM MEM stage and DATA_MEMORY. It is the initiator side of the 128-bit block protocol that DATA_MEMORY responds to. It serves 32-bit CPU loads and stores with byte enables. It fetches and evicts whole 16-byte blocks using MEM_READ/MEM_WRITE, MEM_ADDRESS[27:0] and 128-bit data, and stalls the pipeline through CPU_BUSYWAIT.

Parameters:
INDEX_W, 3, set index width; SETS = 2^INDEX_W lines.
TAG_W, 28-INDEX_W, stored tag width (block address minus index).

Ports:
CLOCK  in  1  single clock; all state updates on posedge.
RESET  in  1  asynchronous, active-high reset.
CPU_READ  in  1  load request.
CPU_WRITE  in  1  store request.
CPU_ADDRESS  in  32  byte address. Fields: [1:0] byte, [3:2] word, [3+INDEX_W:4] index, [31:4+INDEX_W] tag.
CPU_BYTEEN  in  4  store byte-lane enables, lane-aligned.
CPU_WRITEDATA  in  32  store data, lane-aligned.
CPU_READDATA  out  32  load word, combinational on hit.
CPU_BUSYWAIT  out  1  stall request to the pipeline.
MEM_READ  out  1  block fetch request.
MEM_WRITE  out  1  block writeback request.
MEM_ADDRESS  out  28  block address.
MEM_WRITEDATA  out  128  evicted block; byte k is at bits [8k+7:8k].
MEM_READDATA  in  128  fetched block, same byte ordering.
MEM_BUSYWAIT  in  1  high while the memory is serving a request.

Behaviour:
- Reset (async): all valid and dirty bits cleared, state IDLE. MEM_READ, MEM_WRITE and CPU_BUSYWAIT are 0. MEM_ADDRESS and MEM_WRITEDATA are 0. CPU_READDATA is 0. Data and tag arrays are not cleared.
- Access is valid when exactly one of CPU_READ or CPU_WRITE is high. A write with CPU_BYTEEN == 0 is not an access.
- When both CPU_READ and CPU_WRITE are high, the request is ignored: no stall, no state change.
- hit = valid[index] && tag[index] == CPU_ADDRESS tag.
- States: IDLE, WRITEBACK, ALLOCATE, UPDATE.
- IDLE, read hit: CPU_READDATA = selected word in the same cycle; CPU_BUSYWAIT = 0.
- IDLE, write hit: CPU_BUSYWAIT = 0. At the next posedge, the enabled bytes are written and dirty[index] is set.
- IDLE, miss: CPU_BUSYWAIT = 1 combinationally in the same cycle. Next state is WRITEBACK if valid && dirty, otherwise ALLOCATE.
- WRITEBACK: MEM_WRITE = 1, MEM_ADDRESS = {stored tag, index}, MEM_WRITEDATA = line data. When MEM_BUSYWAIT is sampled 0 at a posedge, go to ALLOCATE.
- ALLOCATE: MEM_READ = 1, MEM_ADDRESS = CPU_ADDRESS[31:4]. When MEM_BUSYWAIT is sampled 0 at a posedge, go to UPDATE.
- UPDATE: at the posedge, the line is loaded from MEM_READDATA latched at ALLOCATE exit. tag and valid are set to 1 and dirty to 0. Go to IDLE. The retried access then hits; a write hit sets dirty.
- MEM handshake: the request level is held until completion. The memory raises MEM_BUSYWAIT in the first request cycle and holds it high for N cycles. MEM_READ and MEM_WRITE are never both high.
- CPU_BUSYWAIT is 1 in every non-IDLE state.
- Latency, clean miss: CPU_BUSYWAIT high for N+3 cycles.
- Latency, dirty miss: CPU_BUSYWAIT high for 2N+4 cycles.
- CPU inputs must stay stable while CPU_BUSYWAIT = 1. The controller does not re-check them.
- CPU_READDATA = 0 when there is no read hit in IDLE.
- Reset mid-operation: the controller returns to IDLE immediately. MEM requests drop in the same instant. All lines become invalid, and dirty data is lost by design.
- Index wrap: addresses differing only in tag map to the same line. This is a conflict miss, not aliasing.

Decomposition:
- Package dcache_pkg: state enum (IDLE, WRITEBACK, ALLOCATE, UPDATE), BLOCK_BYTES = 16, BLOCK_W = 128, MEM_ADDR_W = 28, and field-slice helper constants.
- Sub-module dcache_line_store: holds the valid/dirty/tag/data arrays. It has an async-clear of valid/dirty, a byte-enabled word write, a whole-block fill, and combinational lookup outputs.
- The FSM and muxing live in dcache_controller.

Test Plan:
- Reset, then read 0x00000040 with N = 5 → CPU_BUSYWAIT high for 8 cycles. MEM_READ is asserted with MEM_ADDRESS = 0x0000004. The read returns word 0 of the fetched block; MEM_WRITE never rises.
- Repeat read of 0x00000044 → hit: CPU_BUSYWAIT stays 0, CPU_READDATA = word 1 in the same cycle, no MEM activity.
- Write 0xDEADBEEF with BYTEEN = 4'b1111 to 0x00000048 (hit), then read it back → 0xDEADBEEF. Then write byte 0x5A with BYTEEN = 4'b0010 to 0x00000048 → readback 0xDEAD5AEF.
- Read 0x000000C0 (same index 4, new tag) after the dirty line → MEM_WRITE first with MEM_ADDRESS = 0x0000004 and the block containing 0xDEAD5AEF. Then MEM_READ with MEM_ADDRESS = 0x000000C. CPU_BUSYWAIT is high for 2N+4 = 14 cycles.
- CPU_READ and CPU_WRITE both high → no stall, no MEM request, arrays unchanged.
- Assert RESET during ALLOCATE → MEM_READ and CPU_BUSYWAIT go to 0 asynchronously. The next read of the previous hit address misses.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and address-field constants for the direct-mapped data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_W     = 128;
  localparam int MEM_ADDR_W  = 28;
  localparam int WORD_W      = 32;
  localparam int WORD_LSB    = 2;
  localparam int INDEX_LSB   = 4;

endpackage

// File: rtl/dcache_line_store.sv
// Valid/dirty/tag/data arrays with byte-enabled word writes, block fills and combinational lookup.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 28 - INDEX_W
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic [INDEX_W-1:0] index,
  output logic               line_valid,
  output logic               line_dirty,
  output logic [TAG_W-1:0]   line_tag,
  output logic [BLOCK_W-1:0] line_block,
  input  logic               word_wr_en,
  input  logic [1:0]         word_sel,
  input  logic [3:0]         word_byteen,
  input  logic [WORD_W-1:0]  word_data,
  input  logic               fill_en,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [BLOCK_W-1:0] fill_block
);

  localparam int SETS = 1 << INDEX_W;

  logic [SETS-1:0]    valid_q;
  logic [SETS-1:0]    dirty_q;
  logic [TAG_W-1:0]   tag_q  [SETS];
  logic [BLOCK_W-1:0] data_q [SETS];

  assign line_valid = valid_q[index];
  assign line_dirty = dirty_q[index];
  assign line_tag   = tag_q[index];
  assign line_block = data_q[index];

  // Only the status bits are cleared; stale tags and data are masked by valid.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (word_wr_en) begin
      dirty_q[index] <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (fill_en) begin
      tag_q[index]  <= fill_tag;
      data_q[index] <= fill_block;
    end else if (word_wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (word_byteen[k]) begin
          data_q[index][{word_sel, k[1:0], 3'b000} +: 8] <= word_data[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Write-back, write-allocate direct-mapped cache controller between the MEM stage and block memory.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 28 - INDEX_W
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  CPU_READ,
  input  logic                  CPU_WRITE,
  input  logic [31:0]           CPU_ADDRESS,
  input  logic [3:0]            CPU_BYTEEN,
  input  logic [31:0]           CPU_WRITEDATA,
  output logic [31:0]           CPU_READDATA,
  output logic                  CPU_BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
  output logic [BLOCK_W-1:0]    MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]    MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
);

  state_t state;

  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic [1:0]         word_sel;
  logic               unused_addr_bits;

  logic               line_valid;
  logic               line_dirty;
  logic [TAG_W-1:0]   line_tag;
  logic [BLOCK_W-1:0] line_block;
  logic [BLOCK_W-1:0] fill_block;

  logic rd_req;
  logic wr_req;
  logic access;
  logic hit;
  logic idle;

  assign index            = CPU_ADDRESS[INDEX_LSB +: INDEX_W];
  assign tag              = CPU_ADDRESS[31 -: TAG_W];
  assign word_sel         = CPU_ADDRESS[WORD_LSB +: 2];
  assign unused_addr_bits = ^CPU_ADDRESS[1:0];

  // Both strobes high is treated as no request; a write with no lanes enabled is not an access.
  assign rd_req = CPU_READ && !CPU_WRITE;
  assign wr_req = CPU_WRITE && !CPU_READ && (|CPU_BYTEEN);
  assign access = rd_req || wr_req;
  assign hit    = line_valid && (line_tag == tag);
  assign idle   = (state == IDLE);

  // Gating with RESET keeps the stall and read port quiet while reset is held.
  assign CPU_BUSYWAIT = !RESET && (!idle || (access && !hit));
  assign CPU_READDATA = (!RESET && idle && rd_req && hit) ? line_block[{word_sel, 5'b00000} +: 32] : '0;

  dcache_line_store #(
    .INDEX_W(INDEX_W),
    .TAG_W  (TAG_W)
  ) u_line_store (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .index      (index),
    .line_valid (line_valid),
    .line_dirty (line_dirty),
    .line_tag   (line_tag),
    .line_block (line_block),
    .word_wr_en (idle && wr_req && hit),
    .word_sel   (word_sel),
    .word_byteen(CPU_BYTEEN),
    .word_data  (CPU_WRITEDATA),
    .fill_en    (state == UPDATE),
    .fill_tag   (tag),
    .fill_block (fill_block)
  );

  // Fetched block is captured on the cycle the memory completes, then written in UPDATE.
  always_ff @(posedge CLOCK) begin
    if (state == ALLOCATE && !MEM_BUSYWAIT) begin
      fill_block <= MEM_READDATA;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access && !hit) begin
            if (line_valid && line_dirty) begin
              state         <= WRITEBACK;
              MEM_WRITE     <= 1'b1;
              MEM_ADDRESS   <= {line_tag, index};
              MEM_WRITEDATA <= line_block;
            end else begin
              state       <= ALLOCATE;
              MEM_READ    <= 1'b1;
              MEM_ADDRESS <= CPU_ADDRESS[31:4];
            end
          end
        end
        WRITEBACK: begin
          if (!MEM_BUSYWAIT) begin
            state       <= ALLOCATE;
            MEM_WRITE   <= 1'b0;
            MEM_READ    <= 1'b1;
            MEM_ADDRESS <= CPU_ADDRESS[31:4];
          end
        end
        ALLOCATE: begin
          if (!MEM_BUSYWAIT) begin
            state    <= UPDATE;
            MEM_READ <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a behavioural block memory of fixed busy latency.
module tb_dcache_controller;

  localparam int N = 5;

  logic         CLOCK = 1'b0;
  logic         RESET = 1'b1;
  logic         CPU_READ = 1'b0;
  logic         CPU_WRITE = 1'b0;
  logic [31:0]  CPU_ADDRESS = '0;
  logic [3:0]   CPU_BYTEEN = '0;
  logic [31:0]  CPU_WRITEDATA = '0;
  logic [31:0]  CPU_READDATA;
  logic         CPU_BUSYWAIT;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  int compared = 0;
  int mismatched = 0;

  logic [127:0] mem_q [16];
  bit           mem_written [16];
  int           mcnt;

  logic         saw_rd, saw_wr, rd_before_wr, both_high;
  logic [27:0]  rd_addr, wr_addr;
  logic [127:0] wr_data;

  dcache_controller dut (
    .CLOCK        (CLOCK),
    .RESET        (RESET),
    .CPU_READ     (CPU_READ),
    .CPU_WRITE    (CPU_WRITE),
    .CPU_ADDRESS  (CPU_ADDRESS),
    .CPU_BYTEEN   (CPU_BYTEEN),
    .CPU_WRITEDATA(CPU_WRITEDATA),
    .CPU_READDATA (CPU_READDATA),
    .CPU_BUSYWAIT (CPU_BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_WRITE    (MEM_WRITE),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  always #5 CLOCK = ~CLOCK;

  // Block b, word w initially holds 0xB0000000 | b<<8 | w.
  function automatic logic [127:0] pat(input logic [3:0] b);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) begin
      r[32*w +: 32] = {4'hB, 16'h0000, b, 6'h00, 2'(w)};
    end
    return r;
  endfunction

  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mcnt < N);
  assign MEM_READDATA = mem_written[MEM_ADDRESS[3:0]] ? mem_q[MEM_ADDRESS[3:0]] : pat(MEM_ADDRESS[3:0]);

  always @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      mcnt <= 0;
    end else if (MEM_READ || MEM_WRITE) begin
      if (MEM_BUSYWAIT) begin
        mcnt <= mcnt + 1;
      end else begin
        mcnt <= 0;
        if (MEM_WRITE) begin
          mem_q[MEM_ADDRESS[3:0]]       <= MEM_WRITEDATA;
          mem_written[MEM_ADDRESS[3:0]] <= 1'b1;
        end
      end
    end
  end

  // Drives one request, counts stalled cycles and records memory traffic until the hit cycle.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        output int busy, output logic [31:0] rdata);
    @(negedge CLOCK);
    CPU_READ = rd; CPU_WRITE = wr; CPU_ADDRESS = addr; CPU_BYTEEN = be; CPU_WRITEDATA = wd;
    #1;
    busy = 0; saw_rd = 0; saw_wr = 0; rd_before_wr = 0; both_high = 0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    while (CPU_BUSYWAIT && busy < 200) begin
      busy++;
      if (MEM_READ && MEM_WRITE) both_high = 1;
      if (MEM_WRITE && !saw_wr) begin
        saw_wr = 1; wr_addr = MEM_ADDRESS; wr_data = MEM_WRITEDATA;
        if (saw_rd) rd_before_wr = 1;
      end
      if (MEM_READ && !saw_rd) begin
        saw_rd = 1; rd_addr = MEM_ADDRESS;
      end
      @(negedge CLOCK);
      #1;
    end
    rdata = CPU_READDATA;
    @(negedge CLOCK);
    CPU_READ = 0; CPU_WRITE = 0; CPU_BYTEEN = 0;
  endtask

  task automatic test_reset();
    RESET = 1;
    repeat (2) @(negedge CLOCK);
    #1;
    compared++;
    if ({MEM_READ, MEM_WRITE, CPU_BUSYWAIT} !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_ctrl: got rd/wr/busy=%b required 000", {MEM_READ, MEM_WRITE, CPU_BUSYWAIT});
    end
    compared++;
    if (MEM_ADDRESS !== 28'h0 || MEM_WRITEDATA !== 128'h0 || CPU_READDATA !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h required zeros", MEM_ADDRESS, MEM_WRITEDATA, CPU_READDATA);
    end
    @(negedge CLOCK);
    RESET = 0;
  endtask

  task automatic test_clean_miss();
    int busy; logic [31:0] rdata;
    access(1, 0, 32'h40, 4'h0, 32'h0, busy, rdata);
    compared++;
    if (busy !== N + 3) begin
      mismatched++; $display("FAIL clean_miss_latency: got %0d required %0d", busy, N + 3);
    end
    compared++;
    if (!saw_rd || rd_addr !== 28'h4 || saw_wr) begin
      mismatched++; $display("FAIL clean_miss_mem: got rd=%b addr=%h wr=%b required rd=1 addr=0000004 wr=0", saw_rd, rd_addr, saw_wr);
    end
    compared++;
    if (rdata !== 32'hB0000400) begin
      mismatched++; $display("FAIL clean_miss_data: got %h required b0000400", rdata);
    end
  endtask

  task automatic test_read_hit();
    @(negedge CLOCK);
    CPU_READ = 1; CPU_ADDRESS = 32'h44;
    #1;
    compared++;
    if (CPU_BUSYWAIT !== 1'b0 || CPU_READDATA !== 32'hB0000401 || MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0) begin
      mismatched++;
      $display("FAIL read_hit: got busy=%b data=%h mrd=%b mwr=%b required 0 b0000401 0 0", CPU_BUSYWAIT, CPU_READDATA, MEM_READ, MEM_WRITE);
    end
    @(negedge CLOCK);
    CPU_READ = 0;
  endtask

  task automatic test_write_hit();
    int busy; logic [31:0] rdata;
    access(0, 1, 32'h48, 4'b1111, 32'hDEADBEEF, busy, rdata);
    compared++;
    if (busy !== 0) begin
      mismatched++; $display("FAIL write_hit_stall: got %0d required 0", busy);
    end
    access(1, 0, 32'h48, 4'h0, 32'h0, busy, rdata);
    compared++;
    if (rdata !== 32'hDEADBEEF || busy !== 0) begin
      mismatched++; $display("FAIL write_full_readback: got %h busy %0d required deadbeef busy 0", rdata, busy);
    end
    access(0, 1, 32'h48, 4'b0010, 32'h00005A00, busy, rdata);
    access(1, 0, 32'h48, 4'h0, 32'h0, busy, rdata);
    compared++;
    if (rdata !== 32'hDEAD5AEF) begin
      mismatched++; $display("FAIL write_byte_readback: got %h required dead5aef", rdata);
    end
  endtask

  task automatic test_dirty_miss();
    int busy; logic [31:0] rdata;
    access(1, 0, 32'hC0, 4'h0, 32'h0, busy, rdata);
    compared++;
    if (busy !== 2 * N + 4) begin
      mismatched++; $display("FAIL dirty_miss_latency: got %0d required %0d", busy, 2 * N + 4);
    end
    compared++;
    if (!saw_wr || wr_addr !== 28'h4 || wr_data !== 128'hB0000403_DEAD5AEF_B0000401_B0000400) begin
      mismatched++; $display("FAIL dirty_writeback: got wr=%b addr=%h data=%h required block 4 with dead5aef", saw_wr, wr_addr, wr_data);
    end
    compared++;
    if (!saw_rd || rd_addr !== 28'hC || rd_before_wr || both_high) begin
      mismatched++; $display("FAIL dirty_refill: got rd=%b addr=%h early=%b both=%b required 1 000000c 0 0", saw_rd, rd_addr, rd_before_wr, both_high);
    end
    compared++;
    if (rdata !== 32'hB0000C00) begin
      mismatched++; $display("FAIL dirty_miss_data: got %h required b0000c00", rdata);
    end
  endtask

  task automatic test_ignored_requests();
    int busy; logic [31:0] rdata;
    @(negedge CLOCK);
    CPU_READ = 1; CPU_WRITE = 1; CPU_ADDRESS = 32'hC8; CPU_BYTEEN = 4'hF; CPU_WRITEDATA = 32'h11111111;
    #1;
    compared++;
    if (CPU_BUSYWAIT !== 1'b0 || MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0 || CPU_READDATA !== 32'h0) begin
      mismatched++;
      $display("FAIL both_strobes: got busy=%b mrd=%b mwr=%b data=%h required 0 0 0 0", CPU_BUSYWAIT, MEM_READ, MEM_WRITE, CPU_READDATA);
    end
    @(negedge CLOCK);
    CPU_READ = 0; CPU_WRITE = 0; CPU_BYTEEN = 0;
    access(1, 0, 32'hC8, 4'h0, 32'h0, busy, rdata);
    compared++;
    if (rdata !== 32'hB0000C02 || busy !== 0) begin
      mismatched++; $display("FAIL both_strobes_unchanged: got %h busy %0d required b0000c02 busy 0", rdata, busy);
    end
    access(0, 1, 32'h08, 4'h0, 32'h12345678, busy, rdata);
    compared++;
    if (busy !== 0) begin
      mismatched++; $display("FAIL zero_byteen: got %0d stalled cycles required 0", busy);
    end
  endtask

  task automatic test_reset_mid_allocate();
    int busy, waited; logic [31:0] rdata;
    @(negedge CLOCK);
    CPU_READ = 1; CPU_ADDRESS = 32'h20;
    waited = 0;
    while (!MEM_READ && waited < 20) begin
      @(negedge CLOCK);
      waited++;
    end
    compared++;
    if (MEM_READ !== 1'b1) begin
      mismatched++; $display("FAIL mid_alloc_start: got MEM_READ=%b required 1", MEM_READ);
    end
    repeat (2) @(negedge CLOCK);
    RESET = 1;
    #1;
    compared++;
    if (MEM_READ !== 1'b0 || CPU_BUSYWAIT !== 1'b0) begin
      mismatched++; $display("FAIL mid_alloc_reset: got mrd=%b busy=%b required 0 0", MEM_READ, CPU_BUSYWAIT);
    end
    @(negedge CLOCK);
    RESET = 0; CPU_READ = 0;
    access(1, 0, 32'hC4, 4'h0, 32'h0, busy, rdata);
    compared++;
    if (busy !== N + 3 || rdata !== 32'hB0000C01) begin
      mismatched++; $display("FAIL post_reset_miss: got busy %0d data %h required %0d b0000c01", busy, rdata, N + 3);
    end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_read_hit();
    test_write_hit();
    test_dirty_miss();
    test_ignored_requests();
    test_reset_mid_allocate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
